div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: LATENCY, 2, clock cycles allowed for the combinational divider to settle (range 1..15).
REQ-002 clk  input  1  rising-edge clock; only clock of the block.
REQ-003 clr  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a divide; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
REQ-006 a  input  32  dividend; sampled with start.
REQ-007 b  input  32  divisor; sampled with start.
REQ-008 div_dividend  output  32  magnitude dividend driven to the divider.
REQ-009 div_divisor  output  32  magnitude divisor driven to the divider.
REQ-010 div_q  input  32  quotient returned by the divider.
REQ-011 div_r  input  32  remainder returned by the divider.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 div_by_zero  output  1  last accepted request had b == 0.
REQ-015 hi  output  32  remainder result register.
REQ-016 lo  output  32  quotient result register.

Function
REQ-017 The block SHALL be a state machine with states IDLE, WAIT, FIX and DONE.
REQ-018 In IDLE with start=1 and b!=0, the next edge SHALL do all of the following: latch operand signs (is_signed & bit 31), latch magnitudes (negate when the latched sign is 1, else pass through) into div_dividend/div_divisor, clear div_by_zero, load the counter with LATENCY-1, and enter WAIT.
REQ-019 In IDLE with start=1 and b==0, the next edge SHALL enter DONE with hi=a, lo=32'hFFFFFFFF and div_by_zero=1; the divider path SHALL be bypassed.
REQ-020 WAIT SHALL decrement the counter each edge and SHALL move to FIX on the edge where the counter is 0, so WAIT lasts exactly LATENCY cycles.
REQ-021 FIX SHALL last one cycle; on its exit edge, lo SHALL be div_q (negated mod 2^32 when the dividend and divisor signs differ), hi SHALL be div_r (negated when the dividend sign is 1), and the state SHALL become DONE.
REQ-022 DONE SHALL assert done for exactly one cycle and return to IDLE on the next edge.
REQ-023 Non-zero-divisor latency: done SHALL be high in the cycle following the (LATENCY+2)th edge after the edge that sampled start. Zero-divisor latency: done SHALL be high in the cycle following that first edge.
REQ-024 start SHALL be ignored while busy=1, including in DONE. No queuing.
REQ-025 All arithmetic SHALL be modulo 2^32. Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0.
REQ-026 hi, lo and div_by_zero SHALL hold their values from completion until the next accepted start, or until the update point of the next request.
REQ-027 div_dividend and div_divisor SHALL remain stable from entry into WAIT through exit from FIX.

Reset
REQ-028 clr=1 at an edge SHALL force state IDLE, counter 0, busy=0, done=0, div_by_zero=0, hi=0, lo=0, div_dividend=0 and div_divisor=0, regardless of state.
REQ-029 clr SHALL take priority over start at the same edge.
REQ-030 clr asserted mid-operation (WAIT/FIX/DONE) SHALL abort without a done pulse.

Verification
REQ-031 Unsigned a=100, b=7, LATENCY=2 -> done in the cycle following the 4th edge after start; lo=14, hi=2, div_by_zero=0.
REQ-032 Signed a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-033 Signed a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 Any a=0x12345678, b=0 -> done in the cycle after 1 edge; hi=0x12345678, lo=0xFFFFFFFF, div_by_zero=1. A following valid divide clears div_by_zero.
REQ-035 start pulsed during WAIT with different operands -> ignored; the original result completes unchanged.
REQ-036 clr during WAIT -> no done pulse; all outputs 0 on the next cycle; a new start is accepted immediately afterward.

Source files
------------

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - sequencing wrapper around an external combinational 32-bit divider
module div_ctrl #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // counter reload so that WAIT spans exactly LATENCY cycles (count LATENCY-1 down to 0)
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_sign_a;
  logic        r_sign_b;
  logic [31:0] r_dividend;
  logic [31:0] r_divisor;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_dbz;

  logic        w_sign_a;
  logic        w_sign_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_b_zero;
  logic        w_busy;
  logic        w_done;

  // operand signs only matter for signed divides; magnitudes feed the unsigned divider
  assign w_sign_a = is_signed & a[31];
  assign w_sign_b = is_signed & b[31];
  assign w_mag_a  = w_sign_a ? (32'd0 - a) : a;
  assign w_mag_b  = w_sign_b ? (32'd0 - b) : b;
  assign w_b_zero = (b == 32'd0);

  // next-state and status outputs; a zero divisor skips the divider entirely
  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_next = w_b_zero ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = ST_FIX;
        end
      end
      ST_FIX: begin
        w_next = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // state register; clr wins over everything, including a start on the same edge
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // operand capture, settle counter and result registers; results only change at update points
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt      <= 4'd0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_dividend <= 32'd0;
      r_divisor  <= 32'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_dbz      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_b_zero) begin
              r_hi  <= a;
              r_lo  <= 32'hFFFF_FFFF;
              r_dbz <= 1'b1;
            end else begin
              r_sign_a   <= w_sign_a;
              r_sign_b   <= w_sign_b;
              r_dividend <= w_mag_a;
              r_divisor  <= w_mag_b;
              r_dbz      <= 1'b0;
              r_cnt      <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_FIX: begin
          // quotient sign follows sign mismatch, remainder sign follows the dividend
          r_lo <= (r_sign_a ^ r_sign_b) ? (32'd0 - div_q) : div_q;
          r_hi <= r_sign_a ? (32'd0 - div_r) : div_r;
        end
        default: begin
        end
      endcase
    end
  end

  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign busy         = w_busy;
  assign done         = w_done;
  assign div_by_zero  = r_dbz;
  assign hi           = r_hi;
  assign lo           = r_lo;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - randomized and directed checks of div_ctrl against an arithmetic model
module tb_div_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_q = 32'd0;
  logic [31:0] div_r = 32'd0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  div_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .clr(clr), .start(start), .is_signed(is_signed), .a(a), .b(b),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_q(div_q), .div_r(div_r),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference result from plain 64-bit arithmetic (truncating division)
  task automatic ref_div(input logic [31:0] ra, input logic [31:0] rb, input logic rs,
                         output logic [31:0] olo, output logic [31:0] ohi, output logic odbz);
    longint x, y, q, r;
    if (rb == 32'd0) begin
      olo = 32'hFFFF_FFFF; ohi = ra; odbz = 1'b1;
    end else begin
      x = rs ? {{32{ra[31]}}, ra} : {32'd0, ra};
      y = rs ? {{32{rb[31]}}, rb} : {32'd0, rb};
      q = x / y;
      r = x % y;
      olo = q[31:0]; ohi = r[31:0]; odbz = 1'b0;
    end
  endtask

  function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
    longint x;
    x = s ? {{32{v[31]}}, v} : {32'd0, v};
    if (x < 0) x = -x;
    return x[31:0];
  endfunction

  // divider stand-in: returns corrupted values until operands have been stable more than LAT cycles
  int          age = 0;
  logic [31:0] last_dd = 32'd0;
  logic [31:0] last_dv = 32'd0;
  always @(negedge clk) begin
    if (div_dividend === last_dd && div_divisor === last_dv) begin
      if (age < 1000) age++;
    end else begin
      age = 1;
    end
    last_dd = div_dividend;
    last_dv = div_divisor;
    if (div_divisor == 32'd0) begin
      div_q = 32'd0; div_r = 32'd0;
    end else if (age > LAT) begin
      div_q = div_dividend / div_divisor;
      div_r = div_dividend % div_divisor;
    end else begin
      div_q = (div_dividend / div_divisor) ^ 32'h5A5A_5A5A;
      div_r = (div_dividend % div_divisor) ^ 32'hA5A5_A5A5;
    end
  end

  // transaction-level model: one request in flight, results appear when done does
  logic        m_busy = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_dd = 32'd0, m_dv = 32'd0;
  logic        m_dbz = 1'b0;
  logic [31:0] p_hi, p_lo;
  logic        p_dbz;
  always @(posedge clk) begin
    if (clr) begin
      m_busy = 1'b0; m_cnt = 0; m_hi = 32'd0; m_lo = 32'd0;
      m_dbz = 1'b0; m_dd = 32'd0; m_dv = 32'd0;
    end else if (!m_busy) begin
      if (start) begin
        ref_div(a, b, is_signed, p_lo, p_hi, p_dbz);
        m_busy = 1'b1;
        if (b == 32'd0) begin
          m_hi = p_hi; m_lo = p_lo; m_dbz = 1'b1; m_cnt = 0;
        end else begin
          m_dbz = 1'b0;
          m_dd  = mag(a, is_signed);
          m_dv  = mag(b, is_signed);
          m_cnt = LAT + 1;
        end
      end
    end else if (m_cnt == 0) begin
      m_busy = 1'b0;
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_busy && m_cnt == 0});
    chk("dbz", {31'd0, div_by_zero}, {31'd0, m_dbz});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("div_dividend", div_dividend, m_dd);
    chk("div_divisor", div_divisor, m_dv);
  end

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                        input logic [31:0] elo, input logic [31:0] ehi, input logic edbz,
                        input int elat, input bit inject);
    int n;
    @(negedge clk);
    a = ta; b = tb_; is_signed = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 1;
    if (inject) begin
      start = 1'b1; a = ~ta; b = tb_ + 32'd3; is_signed = ~ts;
    end
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    chk("latency", n, elat);
    chk("op_lo", lo, elo);
    chk("op_hi", hi, ehi);
    chk("op_dbz", {31'd0, div_by_zero}, {31'd0, edbz});
  endtask

  logic [31:0] t_lo, t_hi;
  logic        t_dbz;

  initial begin
    clr = 1'b1; start = 1'b0; is_signed = 1'b0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    clr = 1'b0;

    ref_div(32'd100, 32'd7, 1'b0, t_lo, t_hi, t_dbz);
    chk("ref_u_lo", t_lo, 32'd14);
    chk("ref_u_hi", t_hi, 32'd2);
    ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, t_lo, t_hi, t_dbz);
    chk("ref_s_lo", t_lo, 32'hFFFF_FFFD);
    chk("ref_s_hi", t_hi, 32'hFFFF_FFFF);
    ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, t_lo, t_hi, t_dbz);
    chk("ref_ovf_lo", t_lo, 32'h8000_0000);
    chk("ref_ovf_hi", t_hi, 32'd0);

    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, LAT + 2, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT + 2, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, LAT + 2, 1'b0);
    run_op(32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1, 1'b0);
    run_op(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, LAT + 2, 1'b0);
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, LAT + 2, 1'b1);

    // abort in WAIT, then an immediate new request
    @(negedge clk);
    a = 32'd77; b = 32'd5; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_dd", div_dividend, 32'd0);
    run_op(32'd77, 32'd5, 1'b0, 32'd15, 32'd2, 1'b0, LAT + 2, 1'b0);

    // randomized traffic, the compare process does the checking
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      clr   = ($urandom_range(63) == 0);
      start = ($urandom_range(2) == 0);
      is_signed = $urandom_range(1) == 1;
      case ($urandom_range(7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'd1;
        3: b = $urandom_range(15);
        default: b = $urandom;
      endcase
      a = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom;
    end
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    repeat (LAT + 4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
